// File: rtl/mskreg_round_sched.sv
// Control sequencer for the 32-bit masked AES datapath: column load, round
// iteration with randomness-driven stalls, then column output. No share data here.
`timescale 1ns / 1ps

module mskreg_round_sched #(
  parameter int NCOL     = 4,
  parameter int SBOX_LAT = 4,
  parameter int NROUNDS  = 10,
  localparam int IW      = (NCOL > 1) ? $clog2(NCOL) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  input  logic            rnd_valid,
  output logic            rnd_ready,
  output logic            sbox_en,
  output logic [IW-1:0]   issue_col,
  output logic [NCOL-1:0] col_en,
  output logic            col_src,
  output logic            mc_bypass,
  output logic [3:0]      round,
  output logic            busy
);

  localparam int PER = NCOL + SBOX_LAT;
  localparam int CW  = $clog2(PER + 1);
  localparam logic [NCOL-1:0] ONE = NCOL'(1);

  typedef enum logic [1:0] {IDLE, LOAD, ROUND, OUT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    round_q, round_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    round_d   = round_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    rnd_ready = 1'b0;
    sbox_en   = 1'b0;
    issue_col = '0;
    col_en    = '0;
    col_src   = 1'b0;
    mc_bypass = 1'b0;
    case (state_q)
      IDLE, LOAD: begin
        // Held low while reset is asserted so nothing is accepted mid-reset.
        in_ready = !rst;
        if (in_valid && !rst) begin
          col_en = ONE << cnt_q;
          if (cnt_q == CW'(NCOL - 1)) begin
            state_d = ROUND;
            cnt_d   = '0;
            round_d = 4'd1;
          end else begin
            state_d = LOAD;
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
      ROUND: begin
        rnd_ready = rnd_valid;
        sbox_en   = rnd_valid;
        col_src   = 1'b1;
        mc_bypass = (round_q == 4'(NROUNDS));
        issue_col = (cnt_q < CW'(NCOL)) ? IW'(cnt_q) : IW'(NCOL - 1);
        // Without randomness everything freezes, so the pipeline loses nothing.
        if (rnd_valid) begin
          if (cnt_q >= CW'(SBOX_LAT)) col_en = ONE << (cnt_q - CW'(SBOX_LAT));
          if (cnt_q == CW'(PER - 1)) begin
            cnt_d = '0;
            if (round_q < 4'(NROUNDS)) round_d = round_q + 4'd1;
            else state_d = OUT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (cnt_q == CW'(NCOL - 1)) begin
            state_d = IDLE;
            cnt_d   = '0;
            round_d = 4'd0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      round_q <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      round_q <= round_d;
    end
  end

  assign round = round_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_mskreg_round_sched.sv
// Bench for mskreg_round_sched: two instances (SBOX_LAT 4 and 1) share stimulus
// and are checked every cycle against a progress-count model plus literal pins.
`timescale 1ns / 1ps

module tb_mskreg_round_sched;

  localparam int NCOL    = 4;
  localparam int NROUNDS = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, out_ready = 1'b0, rnd_valid = 1'b0;

  logic       in_ready_w [2];
  logic       out_valid_w[2];
  logic       rnd_ready_w[2];
  logic       sbox_en_w  [2];
  logic [1:0] issue_col_w[2];
  logic [3:0] col_en_w   [2];
  logic       col_src_w  [2];
  logic       mc_bypass_w[2];
  logic [3:0] round_w    [2];
  logic       busy_w     [2];

  int tests = 0;
  int fails = 0;

  // Model: columns loaded, round steps advanced, columns delivered.
  int lat  [2] = '{4, 1};
  int nload[2] = '{0, 0};
  int nstep[2] = '{0, 0};
  int nout [2] = '{0, 0};

  always #5 clk = ~clk;

  mskreg_round_sched #(.NCOL(NCOL), .SBOX_LAT(4), .NROUNDS(NROUNDS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .out_valid(out_valid_w[0]), .out_ready(out_ready), .rnd_valid(rnd_valid),
    .rnd_ready(rnd_ready_w[0]), .sbox_en(sbox_en_w[0]), .issue_col(issue_col_w[0]),
    .col_en(col_en_w[0]), .col_src(col_src_w[0]), .mc_bypass(mc_bypass_w[0]),
    .round(round_w[0]), .busy(busy_w[0])
  );

  mskreg_round_sched #(.NCOL(NCOL), .SBOX_LAT(1), .NROUNDS(NROUNDS)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .out_valid(out_valid_w[1]), .out_ready(out_ready), .rnd_valid(rnd_valid),
    .rnd_ready(rnd_ready_w[1]), .sbox_en(sbox_en_w[1]), .issue_col(issue_col_w[1]),
    .col_en(col_en_w[1]), .col_src(col_src_w[1]), .mc_bypass(mc_bypass_w[1]),
    .round(round_w[1]), .busy(busy_w[1])
  );

  task automatic chk(input string name, input int i, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[inst%0d]: got %0h, expected %0h", name, i, act, exp);
    end
  endtask

  task automatic model_check(input int i);
    int p, tot, r, c, ph;
    logic [3:0] e_col;
    p   = NCOL + lat[i];
    tot = NROUNDS * p;
    if (rst) begin
      chk("rst_ctl", i, {in_ready_w[i], out_valid_w[i], rnd_ready_w[i], sbox_en_w[i],
                         col_src_w[i], mc_bypass_w[i], busy_w[i]}, 0);
      chk("rst_vec", i, {issue_col_w[i], col_en_w[i], round_w[i]}, 0);
      nload[i] = 0; nstep[i] = 0; nout[i] = 0;
      return;
    end
    if (nstep[i] == 0 && nload[i] < NCOL) ph = 0;
    else if (nstep[i] < tot) ph = 1;
    else ph = 2;
    r = nstep[i] / p + 1;
    c = nstep[i] % p;
    e_col = 4'd0;
    if (ph == 0 && in_valid) e_col = 4'(1 << nload[i]);
    if (ph == 1 && rnd_valid && c >= lat[i]) e_col = 4'(1 << (c - lat[i]));
    chk("in_ready", i, in_ready_w[i], ph == 0);
    chk("out_valid", i, out_valid_w[i], ph == 2);
    chk("rnd_ready", i, rnd_ready_w[i], ph == 1 && rnd_valid);
    chk("sbox_en", i, sbox_en_w[i], ph == 1 && rnd_valid);
    chk("col_en", i, col_en_w[i], e_col);
    chk("onehot", i, $countones(col_en_w[i]) <= 1, 1);
    if (e_col != 0) chk("col_src", i, col_src_w[i], ph == 1);
    if (ph == 1) chk("issue_col", i, issue_col_w[i], (c < NCOL) ? c : NCOL - 1);
    chk("mc_bypass", i, mc_bypass_w[i], ph == 1 && r == NROUNDS);
    chk("round", i, round_w[i], (ph == 0) ? 0 : (ph == 1) ? r : NROUNDS);
    chk("busy", i, busy_w[i], !(ph == 0 && nload[i] == 0));
    if (ph == 0 && in_valid) nload[i]++;
    else if (ph == 1 && rnd_valid) nstep[i]++;
    else if (ph == 2 && out_ready) begin
      nout[i]++;
      if (nout[i] == NCOL) begin nload[i] = 0; nstep[i] = 0; nout[i] = 0; end
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) model_check(i);
  end

  // Drive one cycle of inputs just after the edge; returns 2 ns after the edge.
  task automatic cyc(input bit iv, input bit rv, input bit orv);
    @(posedge clk);
    #1;
    in_valid  = iv;
    rnd_valid = rv;
    out_ready = orv;
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rstpulse_busy", i, busy_w[i], 0);
      chk("rstpulse_ctl", i, {in_ready_w[i], out_valid_w[i], rnd_ready_w[i],
                              sbox_en_w[i], col_src_w[i], mc_bypass_w[i]}, 0);
      chk("rstpulse_vec", i, {issue_col_w[i], col_en_w[i], round_w[i]}, 0);
      nload[i] = 0; nstep[i] = 0; nout[i] = 0;
    end
    rst = 1'b0;
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 300; k++) begin
      cyc(0, 1, 1);
      if (!busy_w[0] && !busy_w[1]) break;
    end
    if (k == 300) chk("drain_timeout", 0, busy_w[0] | busy_w[1], 0);
  endtask

  int first[2];
  logic [3:0] pat_ce[7] = '{4'd1, 4'd0, 4'd0, 4'd2, 4'd4, 4'd0, 4'd8};
  bit         pat_iv[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Unstalled run: load walk, first-round column enables, latency.
    first = '{-1, -1};
    for (int k = 0; k < 100; k++) begin
      cyc(k < 4, 1, 1);
      if (k < 4) chk("load_walk", 0, col_en_w[0], 32'(1) << k);
      if (k == 8) chk("r1_colen", 0, col_en_w[0], 4'b0001);
      if (k == 5) begin
        chk("lat1_colen", 1, col_en_w[1], 4'b0001);
        chk("lat1_issue", 1, issue_col_w[1], 1);
      end
      if (k == 75) chk("bypass_r9", 0, mc_bypass_w[0], 0);
      if (k == 80) chk("bypass_r10", 0, mc_bypass_w[0], 1);
      for (int i = 0; i < 2; i++) if (first[i] < 0 && out_valid_w[i]) first[i] = k;
    end
    chk("latency", 0, first[0], 84);
    chk("latency", 1, first[1], 54);
    drain();

    // Abort mid-ROUND at round 3, cnt 5, then restart loading.
    for (int k = 0; k < 26; k++) cyc(k < 4, 1, 1);
    chk("pre_abort_round", 0, round_w[0], 3);
    pulse_reset();
    cyc(1, 0, 1);
    chk("restart_col0", 0, col_en_w[0], 4'b0001);
    chk("restart_in_ready", 0, in_ready_w[0], 1);
    repeat (3) cyc(1, 0, 1);
    drain();

    // Randomness stall of 3 cycles at round 2, cnt 5.
    first = '{-1, -1};
    for (int k = 0; k < 100; k++) begin
      cyc(k < 4, !(k >= 17 && k <= 19), 1);
      if (k >= 17 && k <= 19) begin
        chk("stall_round", 0, round_w[0], 2);
        chk("stall_issue", 0, issue_col_w[0], 3);
        chk("stall_quiet", 0, {col_en_w[0], sbox_en_w[0], rnd_ready_w[0]}, 0);
      end
      if (k == 20) chk("stall_resume", 0, col_en_w[0], 4'b0010);
      if (first[0] < 0 && out_valid_w[0]) first[0] = k;
    end
    chk("stall_latency", 0, first[0], 87);
    drain();

    // Gappy input, then output backpressure at column 2.
    for (int k = 0; k < 7; k++) begin
      cyc(pat_iv[k], 0, 1);
      chk("gap_colen", 0, col_en_w[0], pat_ce[k]);
    end
    cyc(0, 0, 1);
    chk("gap_round", 0, round_w[0], 1);
    chk("gap_in_ready", 0, in_ready_w[0], 0);
    begin
      int k;
      for (k = 0; k < 200; k++) begin
        cyc(0, 1, 1);
        if (out_valid_w[0]) break;
      end
      if (k == 200) chk("out_timeout", 0, out_valid_w[0], 1);
    end
    cyc(0, 1, 1);
    repeat (5) begin
      cyc(0, 1, 0);
      chk("bp_out_valid", 0, out_valid_w[0], 1);
      chk("bp_in_ready", 0, in_ready_w[0], 0);
    end
    cyc(0, 1, 1);
    cyc(0, 1, 1);
    cyc(0, 0, 0);
    chk("done_in_ready", 0, in_ready_w[0], 1);
    chk("done_busy", 0, busy_w[0], 0);

    // Random traffic with occasional async reset pulses.
    for (int k = 0; k < 3000; k++) begin
      cyc($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, $urandom_range(0, 4) < 3);
      if ($urandom_range(0, 599) == 0) pulse_reset();
    end

    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mskreg_round_sched.md
Name: mskreg_round_sched

Overview:
- Sequencing controller for the 32-bit masked AES encryption datapath.
- Drives the enable inputs of the per-column masked state registers (hold-when-disabled register banks), the masked S-box pipeline enable and the datapath muxes.
- Runs load -> rounds -> output phases and stalls the masked pipeline whenever fresh randomness is unavailable.
- Carries no share data: only control, so it is verified as plain logic.

Parameters:
- NCOL, 4, number of 32-bit state columns (and column registers).
- SBOX_LAT, 4, cycles from column issue into masked S-box to MixColumns result valid; legal 1..8.
- NROUNDS, 10, AES rounds; last round bypasses MixColumns.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  input column (masked plaintext+key) available.
- in_ready  out  1  controller accepts an input column this cycle.
- out_valid  out  1  output column presented.
- out_ready  in  1  consumer takes output column.
- rnd_valid  in  1  fresh randomness for this S-box cycle available.
- rnd_ready  out  1  randomness consumed this cycle.
- sbox_en  out  1  enable of all masked S-box pipeline registers.
- issue_col  out  clog2(NCOL)  column index fed to S-box input mux.
- col_en  out  NCOL  one-hot (or zero) enable for column registers.
- col_src  out  1  0 = load from input port, 1 = load round result.
- mc_bypass  out  1  1 during last round (skip MixColumns).
- round  out  4  current round, 1..NROUNDS; 0 when idle/loading.
- busy  out  1  not in IDLE.

Behaviour:
- Reset (async): state=IDLE, counters 0. Outputs: in_ready=0, out_valid=0, rnd_ready=0, sbox_en=0, col_en=0, col_src=0, issue_col=0, mc_bypass=0, round=0, busy=0. Reset mid-operation aborts the block immediately; no partial output.
- IDLE:
  - in_ready=1.
  - On in_valid: col_en[0]=1, col_src=0, go LOAD with cnt=1.
- LOAD:
  - in_ready=1.
  - Each in_valid cycle: col_en[cnt]=1, col_src=0, cnt++.
  - Gaps in in_valid: col_en=0, cnt holds.
  - After column NCOL-1 accepted: round=1, go ROUND with cnt=0.
- ROUND (cnt 0..NCOL+SBOX_LAT-1):
  - Advance condition adv = rnd_valid. rnd_ready=sbox_en=adv.
  - If !adv: cnt holds, col_en=0, sbox_en=0 (pipeline and state freeze; no data lost).
  - If adv:
    - issue_col=cnt when cnt<NCOL, else holds last value.
    - col_en=onehot(cnt-SBOX_LAT) when cnt>=SBOX_LAT, else 0; col_src=1.
    - cnt++.
  - At cnt=NCOL+SBOX_LAT-1 with adv:
    - If round<NROUNDS: round++, cnt=0.
    - Else: go OUT with cnt=0.
  - mc_bypass = (round==NROUNDS), constant for the whole round.
- OUT:
  - out_valid=1; datapath presents column cnt.
  - On out_ready: cnt++.
  - After column NCOL-1 taken: go IDLE, round=0.
  - col_en=0 throughout; in_ready=0.
- in_ready=0 in ROUND and OUT; in_valid ignored there.
- Simultaneous: rnd_valid ignored outside ROUND (rnd_ready=0).
- Unstalled latency: NCOL load + NROUNDS*(NCOL+SBOX_LAT) + NCOL output cycles.
- Invariant: col_en has at most one bit set in every cycle.

Test Plan:
- Reset mid-ROUND (round=3, cnt=5), rst pulse between clock edges -> all outputs 0 immediately and busy=0; next in_valid restarts at LOAD column 0.
- Defaults, in_valid and rnd_valid and out_ready held 1 -> col_en walks 0001..1000 in LOAD; each round is 8 cycles with col_en 0001,0010,0100,1000 on cnt=4..7. out_valid first asserted 4+80=84 cycles after the first accepted column; mc_bypass=1 only in round 10.
- rnd_valid=0 for 3 cycles at round 2, cnt=5 -> cnt, issue_col and round frozen; col_en=0, sbox_en=0, rnd_ready=0 during the stall; resumes with col_en=0010 when rnd_valid returns; total latency +3.
- in_valid pattern 1,0,0,1,1,0,1 -> exactly 4 col_en pulses (0001,0010,0100,1000) only on the in_valid cycles; ROUND is entered after the 4th.
- out_ready low for 5 cycles in OUT at cnt=2 -> out_valid stays 1 and column 2 is held; in_ready=0 until the final column is taken, then IDLE with in_ready=1.
- SBOX_LAT=1 -> each round is 5 cycles; col_en=0001 at cnt=1, with issue of column 1 in the same cycle.
